online_div_ctrl: RTL and testbench
==================================

Name: online_div_ctrl

Overview:
- Sequencer for the radix-2 signed-digit online divider datapath: residual recurrence registers plus the quotient-digit selection (V) block.
- Accepts MSD-first dividend/divisor digit streams with a valid/ready handshake and enforces the online delay.
- Drives the residual step/clear strobes and the selection-block fixing/preset inputs, then registers and emits quotient digits.
- Sits between the operand digit sources and the divider datapath; one division in flight at a time.

Parameters:
- N_DIGITS, 16: number of input digit pairs consumed and quotient digits produced per division (>= ONLINE_DELAY+1).
- ONLINE_DELAY, 3: online delay delta; number of input cycles before the first quotient digit is selected.
- CNT_W, 5: width of the digit counters; must satisfy 2^CNT_W > N_DIGITS.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a division; sampled in IDLE only
- abort  in  1  synchronous abandon; forces IDLE at next edge
- in_valid  in  1  operand digit pair present
- in_ready  out  1  controller accepts a digit pair this cycle
- x_plus, x_minus  in  1 each  dividend digit, signed-digit encoding
- d_plus, d_minus  in  1 each  divisor digit, same encoding
- dp_x_plus, dp_x_minus, dp_d_plus, dp_d_minus  out  1 each  digits forwarded to the datapath
- dp_clr  out  1  clear residual/operand registers
- dp_step  out  1  advance residual recurrence one step
- fixing  out  1  to selection block; 1 forces the estimate to pre_p_value
- pre_p_value  out  1  preset estimate; constant 0
- estimated_q  in  2  selection-block output: 2'b10=+1, 2'b01=-1, 2'b00=0
- q_plus, q_minus  out  1 each  registered quotient digit
- q_valid  out  1  q_plus/q_minus hold a new digit this cycle
- q_index  out  CNT_W  index of the digit on q_plus/q_minus, 0 = MSD
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: division complete

Behaviour:
- Reset: state IDLE; all counters 0; in_ready, dp_clr, dp_step, fixing, q_plus, q_minus, q_valid, done, busy = 0; q_index = 0.
- States: IDLE, INIT, DELAY, ITER, FLUSH, DONE.
- IDLE: start=1 -> INIT. in_ready=0.
- INIT, one cycle: dp_clr=1, fixing=1, counters cleared -> DELAY.
- DELAY: in_ready=1, fixing=1. Each accepted pair (in_valid & in_ready) sets dp_step=1 and increments in_cnt. No quotient capture. After the ONLINE_DELAY-th accept -> ITER.
- ITER: in_ready=1, fixing=0. On accept: dp_step=1, in_cnt++, capture estimated_q. After the accept that makes in_cnt=N_DIGITS -> FLUSH.
- FLUSH: in_ready=0; forwarded digits forced to 0; dp_step=1 every cycle; capture every cycle. After ONLINE_DELAY cycles -> DONE.
- DONE, one cycle: done=1 -> IDLE.
- Stall: when in_valid=0 in DELAY/ITER, dp_step=0, no capture, and counters and state hold.
- Forwarding: dp_* digits equal the inputs when in_ready=1, otherwise 0.
- Capture: at the edge, q_plus=estimated_q[1], q_minus=estimated_q[0], and q_index=out_cnt; then out_cnt++. q_valid=1 for exactly the cycle after each capture. 2'b11 is captured as digit 0 (both low).
- Count/latency: exactly N_DIGITS captures per division. Final q_valid coincides with done. With in_valid held at 1, the done cycle follows start by 2+N_DIGITS+ONLINE_DELAY cycles.
- start while busy is ignored. start and abort both high in IDLE: abort wins and state stays IDLE.
- abort in any non-IDLE state -> IDLE at next edge; no done pulse; q_valid=0 thereafter.
- rst_n low at any time -> immediate reset values; partial results are discarded.

Optional Feature:
- ONLINE_DIV_DIGIT_CHECK_EN defined: adds output digit_err (1 bit). It is set at the edge accepting any pair with x_plus&x_minus or d_plus&d_minus. It is sticky until the next INIT and cleared by reset.
- Not defined: port absent; illegal pairs are forwarded unchanged and never flagged.

Test Plan:
- N_DIGITS=8, ONLINE_DELAY=3, in_valid=1, start pulsed at edge 0 -> dp_clr high in cycle 1; fixing high in cycles 1-4; in_ready high for 8 cycles; q_valid pulses 8 times with q_index 0..7; done in cycle 13; busy falls after it.
- estimated_q sequence 10,01,00,11,10,10,01,00 on successive captures -> (q_plus,q_minus) = 10,01,00,00,10,10,01,00.
- in_valid dropped for 2 cycles mid-ITER -> dp_step=0, no q_valid, counters hold; done is delayed by exactly 2 cycles.
- abort asserted in the 3rd ITER cycle -> IDLE next edge; busy=0, no done; a following start runs a full clean 8-digit division.
- rst_n pulsed low in FLUSH -> all outputs zero immediately; start during busy has no effect on digit count or done timing.
- With ONLINE_DIV_DIGIT_CHECK_EN: x_plus=x_minus=1 on the 2nd accept -> digit_err=1 from the next cycle through done; cleared by the next start's INIT.

Source files
------------

// File: rtl/online_div_ctrl_if.sv
// Operand digit-pair stream into the online divider controller.
// Source drives valid and signed digits, controller answers with ready.
interface online_div_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic x_plus;
  logic x_minus;
  logic d_plus;
  logic d_minus;

  modport master (
    output in_valid,
    output x_plus,
    output x_minus,
    output d_plus,
    output d_minus,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  x_plus,
    input  x_minus,
    input  d_plus,
    input  d_minus,
    output in_ready
  );
endinterface

// File: rtl/online_div_ctrl.sv
// Sequencer for a radix-2 signed-digit online divider datapath.
// Optional ONLINE_DIV_DIGIT_CHECK_EN adds a sticky illegal-digit flag.
module online_div_ctrl #(
  parameter int N_DIGITS     = 16,
  parameter int ONLINE_DELAY = 3,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  online_div_ctrl_if.slave in_if,
  output logic             dp_x_plus,
  output logic             dp_x_minus,
  output logic             dp_d_plus,
  output logic             dp_d_minus,
  output logic             dp_clr,
  output logic             dp_step,
  output logic             fixing,
  output logic             pre_p_value,
  input  logic [1:0]       estimated_q,
  output logic             q_plus,
  output logic             q_minus,
  output logic             q_valid,
  output logic [CNT_W-1:0] q_index,
  output logic             busy,
`ifdef ONLINE_DIV_DIGIT_CHECK_EN
  output logic             digit_err,
`endif
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DELAY,
    S_ITER,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] DLY_M1 =
    CNT_W'(ONLINE_DELAY - 1);
  localparam logic [CNT_W-1:0] NDG_M1 =
    CNT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  logic             q_plus_q, q_minus_q;
  logic             q_valid_q;
  logic [CNT_W-1:0] q_index_q;

  logic rdy;
  logic capture;
  logic accept;
  logic q_plus_d, q_minus_d;

  assign accept = in_if.in_valid & rdy;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    rdy       = 1'b0;
    dp_clr    = 1'b0;
    dp_step   = 1'b0;
    fixing    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        dp_clr    = 1'b1;
        fixing    = 1'b1;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        fl_cnt_d  = '0;
        state_d   = S_DELAY;
      end
      S_DELAY: begin
        rdy    = 1'b1;
        fixing = 1'b1;
        if (in_if.in_valid) begin
          dp_step  = 1'b1;
          in_cnt_d = in_cnt_q + ONE;
          if (in_cnt_q == DLY_M1)
            state_d = S_ITER;
        end
      end
      S_ITER: begin
        rdy = 1'b1;
        if (in_if.in_valid) begin
          dp_step  = 1'b1;
          capture  = 1'b1;
          in_cnt_d = in_cnt_q + ONE;
          if (in_cnt_q == NDG_M1) begin
            fl_cnt_d = '0;
            state_d  = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Drain the online delay with zero-digit inputs.
        dp_step  = 1'b1;
        capture  = 1'b1;
        fl_cnt_d = fl_cnt_q + ONE;
        if (fl_cnt_q == DLY_M1)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (capture)
      out_cnt_d = out_cnt_q + ONE;
    // Abort overrides everything, including a start in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      capture = 1'b0;
    end
  end

  always_comb begin
    q_plus_d  = 1'b0;
    q_minus_d = 1'b0;
    unique case (1'b1)
      (estimated_q == 2'b10): q_plus_d  = 1'b1;
      (estimated_q == 2'b01): q_minus_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fl_cnt_q  <= '0;
      q_plus_q  <= 1'b0;
      q_minus_q <= 1'b0;
      q_valid_q <= 1'b0;
      q_index_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      q_valid_q <= capture;
      if (capture) begin
        q_plus_q  <= q_plus_d;
        q_minus_q <= q_minus_d;
        q_index_q <= out_cnt_q;
      end
    end
  end

`ifdef ONLINE_DIV_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic bad_pair;

  assign bad_pair =
    (in_if.x_plus & in_if.x_minus) |
    (in_if.d_plus & in_if.d_minus);

  always_comb begin
    err_d = err_q;
    if (state_q == S_INIT)
      err_d = 1'b0;
    else if (accept & bad_pair)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign digit_err = err_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign in_if.in_ready = rdy;
  assign dp_x_plus   = rdy & in_if.x_plus;
  assign dp_x_minus  = rdy & in_if.x_minus;
  assign dp_d_plus   = rdy & in_if.d_plus;
  assign dp_d_minus  = rdy & in_if.d_minus;
  assign pre_p_value = 1'b0;
  assign q_plus      = q_plus_q;
  assign q_minus     = q_minus_q;
  assign q_valid     = q_valid_q;
  assign q_index     = q_index_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_online_div_ctrl.sv
// Directed bench for online_div_ctrl with N_DIGITS=8, ONLINE_DELAY=3.
// Cycle k means the period after the k-th edge, start sampled at edge 0.
module tb_online_div_ctrl;
  localparam int N = 8;
  localparam int D = 3;
  localparam int W = 5;
  localparam int HC = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] est = 2'b00;

  logic dp_x_plus, dp_x_minus, dp_d_plus, dp_d_minus;
  logic dp_clr, dp_step, fixing, pre_p_value;
  logic q_plus, q_minus, q_valid, busy, done;
  logic [W-1:0] q_index;
`ifdef ONLINE_DIV_DIGIT_CHECK_EN
  logic digit_err;
`endif

  online_div_ctrl_if bus ();

  online_div_ctrl #(
    .N_DIGITS(N), .ONLINE_DELAY(D), .CNT_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .in_if(bus.slave),
    .dp_x_plus(dp_x_plus), .dp_x_minus(dp_x_minus),
    .dp_d_plus(dp_d_plus), .dp_d_minus(dp_d_minus),
    .dp_clr(dp_clr), .dp_step(dp_step),
    .fixing(fixing), .pre_p_value(pre_p_value),
    .estimated_q(est),
    .q_plus(q_plus), .q_minus(q_minus),
    .q_valid(q_valid), .q_index(q_index),
    .busy(busy),
`ifdef ONLINE_DIV_DIGIT_CHECK_EN
    .digit_err(digit_err),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  logic ir_h [HC];
  logic st_h [HC];
  logic qv_h [HC];
  logic dn_h [HC];
  logic bz_h [HC];
  logic fx_h [HC];
  logic cl_h [HC];
  logic er_h [HC];
  logic [1:0]   qval [16];
  logic [W-1:0] qidx [16];
  int nq;
  int fwd_err;

  logic [1:0] seq [8] = '{2'b10, 2'b01, 2'b00, 2'b11,
                          2'b10, 2'b10, 2'b01, 2'b00};
  logic [1:0] exq [8] = '{2'b10, 2'b01, 2'b00, 2'b00,
                          2'b10, 2'b10, 2'b01, 2'b00};

  // Start is pulsed into edge 0; records cycles 1..ncyc-1.
  task automatic run(input int ncyc, input int stall_from,
                     input int stall_len, input int abort_at,
                     input int st_from, input int st_to,
                     input int bad_cyc);
    nq = 0;
    fwd_err = 0;
    for (int i = 0; i < HC; i++) begin
      ir_h[i] = 0; st_h[i] = 0; qv_h[i] = 0; dn_h[i] = 0;
      bz_h[i] = 0; fx_h[i] = 0; cl_h[i] = 0; er_h[i] = 0;
    end
    est = seq[0];
    bus.in_valid = 1'b0;
    start = 1'b1;
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start = (c >= st_from && c <= st_to);
      abort = (c == abort_at);
      bus.in_valid = !(c >= stall_from && c < stall_from + stall_len);
      bus.x_plus = 1'b1;
      bus.x_minus = (c == bad_cyc);
      bus.d_plus = 1'b0;
      bus.d_minus = 1'b1;
      #1;
      ir_h[c] = bus.in_ready;
      st_h[c] = dp_step;
      qv_h[c] = q_valid;
      dn_h[c] = done;
      bz_h[c] = busy;
      fx_h[c] = fixing;
      cl_h[c] = dp_clr;
`ifdef ONLINE_DIV_DIGIT_CHECK_EN
      er_h[c] = digit_err;
`endif
      if (dp_x_plus !== bus.in_ready ||
          dp_x_minus !== (bus.in_ready & bus.x_minus) ||
          dp_d_plus !== 1'b0 ||
          dp_d_minus !== bus.in_ready ||
          pre_p_value !== 1'b0)
        fwd_err++;
      if (q_valid) begin
        if (nq < 16) begin
          qval[nq] = {q_plus, q_minus};
          qidx[nq] = q_index;
        end
        nq++;
      end
      est = (nq < 8) ? seq[nq] : 2'b00;
    end
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.x_plus = 1'b0; bus.x_minus = 1'b0;
    bus.d_plus = 1'b0; bus.d_minus = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({busy, done, q_valid, q_plus, q_minus, dp_clr, dp_step,
         fixing, bus.in_ready, q_index} !== {9'b0, 5'd0})
      $display("FAIL reset_outputs got busy=%b done=%b qv=%b idx=%0d want all 0",
               busy, done, q_valid, q_index);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || dp_clr !== 1'b0)
      $display("FAIL start_abort_idle got busy=%b dp_clr=%b want 0 0",
               busy, dp_clr);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int bad, dc, dn;
    run(16, 99, 0, 0, 99, 99, 99);
    bad = 0;
    for (int c = 1; c < 16; c++)
      if (cl_h[c] !== (c == 1)) bad++;
    total++;
    if (bad != 0) $display("FAIL dp_clr_cycle got %0d bad cycles want 0", bad);
    else pass_cnt++;
    bad = 0;
    for (int c = 1; c < 16; c++)
      if (fx_h[c] !== (c >= 1 && c <= 4)) bad++;
    total++;
    if (bad != 0) $display("FAIL fixing_window got %0d bad cycles want 0", bad);
    else pass_cnt++;
    bad = 0;
    for (int c = 1; c < 16; c++)
      if (ir_h[c] !== (c >= 2 && c <= 9)) bad++;
    total++;
    if (bad != 0) $display("FAIL in_ready_window got %0d bad cycles want 0", bad);
    else pass_cnt++;
    bad = 0;
    for (int c = 1; c < 16; c++)
      if (st_h[c] !== (c >= 2 && c <= 12)) bad++;
    total++;
    if (bad != 0) $display("FAIL dp_step_window got %0d bad cycles want 0", bad);
    else pass_cnt++;
    total++;
    if (nq != N) $display("FAIL q_count got %0d want %0d", nq, N);
    else pass_cnt++;
    bad = 0;
    for (int c = 1; c < 16; c++)
      if (qv_h[c] !== (c >= 6 && c <= 13)) bad++;
    for (int k = 0; k < N && k < nq; k++)
      if (qidx[k] !== W'(k)) bad++;
    total++;
    if (bad != 0) $display("FAIL q_valid_index got %0d bad want 0", bad);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < N && k < nq; k++)
      if (qval[k] !== exq[k]) bad++;
    total++;
    if (bad != 0) $display("FAIL q_digits got %0d wrong digits want 0", bad);
    else pass_cnt++;
    dc = -1; dn = 0;
    for (int c = 1; c < 16; c++)
      if (dn_h[c]) begin dn++; if (dc < 0) dc = c; end
    total++;
    if (dc != 13 || dn != 1)
      $display("FAIL done_cycle got cycle %0d count %0d want 13 1", dc, dn);
    else pass_cnt++;
    total++;
    if (bz_h[13] !== 1'b1 || bz_h[14] !== 1'b0 || bz_h[1] !== 1'b1)
      $display("FAIL busy_span got %b%b%b want 110",
               bz_h[1], bz_h[13], bz_h[14]);
    else pass_cnt++;
    total++;
    if (fwd_err != 0) $display("FAIL forwarding got %0d bad cycles want 0", fwd_err);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int dc, bad;
    run(20, 6, 2, 0, 99, 99, 99);
    total++;
    if (st_h[6] !== 1'b0 || st_h[7] !== 1'b0 || st_h[8] !== 1'b1)
      $display("FAIL stall_step got %b%b%b want 001", st_h[6], st_h[7], st_h[8]);
    else pass_cnt++;
    total++;
    if (qv_h[7] !== 1'b0 || qv_h[8] !== 1'b0 || qv_h[9] !== 1'b1)
      $display("FAIL stall_qvalid got %b%b%b want 001", qv_h[7], qv_h[8], qv_h[9]);
    else pass_cnt++;
    dc = -1;
    for (int c = 1; c < 20; c++) if (dn_h[c] && dc < 0) dc = c;
    total++;
    if (dc != 15) $display("FAIL stall_done got cycle %0d want 15", dc);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < N && k < nq; k++)
      if (qval[k] !== exq[k] || qidx[k] !== W'(k)) bad++;
    total++;
    if (nq != N || bad != 0)
      $display("FAIL stall_digits got count %0d bad %0d want %0d 0", nq, bad, N);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int bad, dc;
    run(20, 99, 0, 7, 99, 99, 99);
    total++;
    if (bz_h[7] !== 1'b1 || bz_h[8] !== 1'b0)
      $display("FAIL abort_busy got %b%b want 10", bz_h[7], bz_h[8]);
    else pass_cnt++;
    bad = 0;
    for (int c = 1; c < 20; c++) if (dn_h[c]) bad++;
    for (int c = 8; c < 20; c++) if (qv_h[c]) bad++;
    total++;
    if (bad != 0 || nq != 2)
      $display("FAIL abort_quiet got %0d stray pulses q_count %0d want 0 2", bad, nq);
    else pass_cnt++;
    run(16, 99, 0, 0, 99, 99, 99);
    dc = -1;
    for (int c = 1; c < 16; c++) if (dn_h[c] && dc < 0) dc = c;
    bad = 0;
    for (int k = 0; k < N && k < nq; k++)
      if (qval[k] !== exq[k] || qidx[k] !== W'(k)) bad++;
    total++;
    if (dc != 13 || nq != N || bad != 0)
      $display("FAIL after_abort got done %0d count %0d bad %0d want 13 %0d 0",
               dc, nq, bad, N);
    else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    int dc;
    bus.in_valid = 1'b1;
    bus.x_plus = 1'b1; bus.x_minus = 1'b0;
    bus.d_plus = 1'b0; bus.d_minus = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0 || dp_step !== 1'b1 ||
        dp_x_plus !== 1'b0)
      $display("FAIL flush_state got busy=%b rdy=%b step=%b dpx=%b want 1010",
               busy, bus.in_ready, dp_step, dp_x_plus);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, q_valid, q_plus, q_minus, dp_step,
         bus.in_ready, q_index} !== {7'b0, 5'd0})
      $display("FAIL async_reset got busy=%b qv=%b step=%b idx=%0d want 0",
               busy, q_valid, dp_step, q_index);
    else pass_cnt++;
    #3;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    run(16, 99, 0, 0, 3, 8, 99);
    dc = -1;
    for (int c = 1; c < 16; c++) if (dn_h[c] && dc < 0) dc = c;
    total++;
    if (dc != 13 || nq != N)
      $display("FAIL start_while_busy got done %0d count %0d want 13 %0d",
               dc, nq, N);
    else pass_cnt++;
  endtask

`ifdef ONLINE_DIV_DIGIT_CHECK_EN
  task automatic test_digit_err();
    int bad;
    run(16, 99, 0, 0, 99, 99, 3);
    bad = 0;
    for (int c = 1; c < 14; c++)
      if (er_h[c] !== (c >= 4)) bad++;
    total++;
    if (bad != 0) $display("FAIL digit_err_set got %0d bad cycles want 0", bad);
    else pass_cnt++;
    run(6, 99, 0, 0, 99, 99, 99);
    total++;
    if (er_h[1] !== 1'b1 || er_h[2] !== 1'b0)
      $display("FAIL digit_err_clear got %b%b want 10", er_h[1], er_h[2]);
    else pass_cnt++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_basic();
    test_stall();
    test_abort();
    test_reset_flush();
`ifdef ONLINE_DIV_DIGIT_CHECK_EN
    test_digit_err();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
